mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback selector for the 5-stage MIPS core.
- Captures memory-stage results on posedge and aligns and extends load data.
- Selects the writeback source and drives the write port of the register file (RegWrite/AddrRd/DataRd). The register file writes on the following negedge.
- Also provides a retired-instruction counter and a misaligned-load pulse.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter (wraps at 2^COUNT_WIDTH)
BIG_ENDIAN, 1, 1: byte offset 0 = bits [31:24]; 0: byte offset 0 = bits [7:0]

Ports:
clock__i  in  1  core clock, all state on posedge
reset_n__i  in  1  asynchronous active-low reset
Stall__i  in  1  hold all stage state
Flush__i  in  1  insert bubble
Valid__i  in  1  MEM stage holds a real instruction
RegWrite__i  in  1  instruction writes a GPR
MemToReg__i  in  1  writeback source is load data
Link__i  in  1  writeback source is PC+8 (jal/jalr)
LoadSize__i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
LoadSigned__i  in  1  sign-extend byte/half loads
ByteOffset__i  in  2  low address bits of the load
AddrRd__i  in  5  destination register
AluResult__i  in  32  ALU result
MemData__i  in  32  raw data-memory read word
Pc4__i  in  32  PC+4 of the instruction
RegWrite__o  out  1  to register file write enable
AddrRd__o  out  5  to register file write address
DataRd__o  out  32  to register file write data; also the forwarding source
Valid__o  out  1  WB stage holds a real instruction
Misaligned__o  out  1  one-cycle pulse: misaligned load dropped
RetireCount__o  out  COUNT_WIDTH  retired-instruction count

Behaviour:
- Reset (asynchronous, reset_n__i=0): every output is 0, counter is 0. Release takes effect on the next posedge.
- Per-posedge priority: Flush > Stall > Capture.
- Flush:
  - Valid__o, RegWrite__o, AddrRd__o, DataRd__o and Misaligned__o go to 0.
  - Counter holds.
  - Flush wins over a simultaneous Stall.
- Stall:
  - All registered outputs hold, including RegWrite__o. A stalled write is re-presented, which is harmless because it is idempotent.
  - Misaligned__o goes to 0.
  - Counter holds.
- Capture (no Flush, no Stall): latency is exactly 1 cycle, inputs at edge N become outputs after edge N.
  - Valid__o gets Valid__i; AddrRd__o gets AddrRd__i.
  - Misaligned condition (mis) = Valid__i & MemToReg__i & ((half & ByteOffset[0]) | (word & ByteOffset!=0)).
  - RegWrite__o gets Valid__i & RegWrite__i & (AddrRd__i!=0) & ~mis.
  - Misaligned__o gets mis (high for exactly one cycle).
  - DataRd__o source priority: Link__i gives Pc4__i+4 (mod 2^32); else MemToReg__i gives aligned load; else AluResult__i.
  - Counter increments by 1 if Valid__i & ~mis, wrapping to 0 after all-ones.
- Load alignment (BIG_ENDIAN=1):
  - Byte k = MemData[31-8k -: 8].
  - Half at offset 0 = [31:16]; at offset 2 = [15:0].
  - Signed loads replicate the MSB of the selected field; unsigned loads zero-extend.
  - Word passes unchanged.
  - BIG_ENDIAN=0 mirrors the lanes.
- Writes to $0 are suppressed here (RegWrite__o=0) but DataRd__o still shows the value.
- Valid__i=0: RegWrite__o=0, counter holds, and DataRd__o is still loaded (don't-care for consumers).
- The block has no combinational path from any input to any output.

Decomposition:
- mips_pkg holds:
  - load_size_t enum (LS_BYTE, LS_HALF, LS_WORD)
  - the REG_ZERO constant (5'd0)
  - WORD_W = 32
  - the LINK_OFFSET = 4 constant
- Sub-module load_align (purely combinational) takes MemData, ByteOffset, LoadSize, LoadSigned and BIG_ENDIAN, and produces the 32-bit aligned value plus the misaligned flag.

Test Plan:
- Reset mid-stream: assert reset_n__i low between edges -> all outputs 0 immediately, before any clock edge; RetireCount__o=0.
- ALU writeback: Valid=1, RegWrite=1, AddrRd=5, AluResult=0x1234_5678 -> next cycle RegWrite__o=1, AddrRd__o=5, DataRd__o=0x1234_5678, RetireCount__o=1.
- Loads with BIG_ENDIAN=1, MemData=0x80FF_7F01:
  - lb signed, offset 0 -> 0xFFFF_FF80
  - lbu, offset 3 -> 0x0000_0001
  - lh signed, offset 2 -> 0x0000_7F01
  - lh signed, offset 0 -> 0xFFFF_80FF
- Misaligned and $0 cases:
  - lw with offset 2 -> RegWrite__o=0, Misaligned__o=1 for one cycle, counter unchanged.
  - Write to AddrRd=0 -> RegWrite__o=0, counter incremented.
- Stall/flush sequencing:
  - jal with Pc4=0x0040_0004, AddrRd=31 -> DataRd__o=0x0040_0008.
  - Stall 2 cycles -> outputs held.
  - Stall and Flush together -> Valid__o=0, RegWrite__o=0.
- Counter wrap with COUNT_WIDTH=4: 16 valid captures -> RetireCount__o returns to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline stages.
package mips_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam int unsigned LINK_OFFSET = 4;

    // Encoding 2'b11 is reserved and handled as a word load.
    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_t;

endpackage

// File: rtl/load_align.sv
// Combinational load-data lane selection and extension, with misalignment detection.
module load_align
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [WORD_W-1:0] mem_data,
    input  logic [1:0]        byte_offset,
    input  logic [1:0]        load_size,
    input  logic              load_signed,
    output logic [WORD_W-1:0] data,
    output logic              misaligned
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Big-endian puts offset 0 in the top lane, so the shift uses the inverted offset.
        byte_shift = BIG_ENDIAN ? {~byte_offset, 3'b000} : {byte_offset, 3'b000};
        half_shift = BIG_ENDIAN ? {~byte_offset[1], 4'b0000} : {byte_offset[1], 4'b0000};
        byte_lane  = 8'(mem_data >> byte_shift);
        half_lane  = 16'(mem_data >> half_shift);
        data       = mem_data;
        misaligned = 1'b0;
        case (load_size)
            LS_BYTE: data = {{(WORD_W-8){load_signed & byte_lane[7]}}, byte_lane};
            LS_HALF: begin
                data       = {{(WORD_W-16){load_signed & half_lane[15]}}, half_lane};
                misaligned = byte_offset[0];
            end
            default: misaligned = (byte_offset != 2'b00);
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures memory results, selects writeback data,
// drives the register-file write port and counts retired instructions.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  logic                   clock__i,
    input  logic                   reset_n__i,
    input  logic                   Stall__i,
    input  logic                   Flush__i,
    input  logic                   Valid__i,
    input  logic                   RegWrite__i,
    input  logic                   MemToReg__i,
    input  logic                   Link__i,
    input  logic [1:0]             LoadSize__i,
    input  logic                   LoadSigned__i,
    input  logic [1:0]             ByteOffset__i,
    input  logic [4:0]             AddrRd__i,
    input  logic [31:0]            AluResult__i,
    input  logic [31:0]            MemData__i,
    input  logic [31:0]            Pc4__i,
    output logic                   RegWrite__o,
    output logic [4:0]             AddrRd__o,
    output logic [31:0]            DataRd__o,
    output logic                   Valid__o,
    output logic                   Misaligned__o,
    output logic [COUNT_WIDTH-1:0] RetireCount__o
);

    logic [WORD_W-1:0] load_data;
    logic              load_mis;
    logic              mis;
    logic [WORD_W-1:0] wb_data;

    load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
        .mem_data    (MemData__i),
        .byte_offset (ByteOffset__i),
        .load_size   (LoadSize__i),
        .load_signed (LoadSigned__i),
        .data        (load_data),
        .misaligned  (load_mis)
    );

    always_comb begin
        mis = Valid__i & MemToReg__i & load_mis;
        if (Link__i)
            wb_data = Pc4__i + WORD_W'(LINK_OFFSET);
        else if (MemToReg__i)
            wb_data = load_data;
        else
            wb_data = AluResult__i;
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            RegWrite__o    <= 1'b0;
            AddrRd__o      <= '0;
            DataRd__o      <= '0;
            Valid__o       <= 1'b0;
            Misaligned__o  <= 1'b0;
            RetireCount__o <= '0;
        end else if (Flush__i) begin
            RegWrite__o   <= 1'b0;
            AddrRd__o     <= '0;
            DataRd__o     <= '0;
            Valid__o      <= 1'b0;
            Misaligned__o <= 1'b0;
        end else if (Stall__i) begin
            Misaligned__o <= 1'b0;
        end else begin
            Valid__o      <= Valid__i;
            AddrRd__o     <= AddrRd__i;
            DataRd__o     <= wb_data;
            RegWrite__o   <= Valid__i & RegWrite__i & (AddrRd__i != REG_ZERO) & ~mis;
            Misaligned__o <= mis;
            if (Valid__i & ~mis)
                RetireCount__o <= RetireCount__o + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (big- and little-endian instances).
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, valid, reg_write, mem_to_reg, link, load_signed;
    logic [1:0]  load_size, byte_offset;
    logic [4:0]  addr_rd;
    logic [31:0] alu_result, mem_data, pc4;

    logic        be_rw, be_valid, be_mis;
    logic [4:0]  be_rd;
    logic [31:0] be_data;
    logic [3:0]  be_count;

    logic        le_rw, le_valid, le_mis;
    logic [4:0]  le_rd;
    logic [31:0] le_data;
    logic [3:0]  le_count;

    int errors = 0;
    int checks = 0;
    int exp_count;

    mem_wb_stage #(.COUNT_WIDTH(4), .BIG_ENDIAN(1'b1)) dut (
        .clock__i(clk), .reset_n__i(rst_n), .Stall__i(stall), .Flush__i(flush),
        .Valid__i(valid), .RegWrite__i(reg_write), .MemToReg__i(mem_to_reg), .Link__i(link),
        .LoadSize__i(load_size), .LoadSigned__i(load_signed), .ByteOffset__i(byte_offset),
        .AddrRd__i(addr_rd), .AluResult__i(alu_result), .MemData__i(mem_data), .Pc4__i(pc4),
        .RegWrite__o(be_rw), .AddrRd__o(be_rd), .DataRd__o(be_data), .Valid__o(be_valid),
        .Misaligned__o(be_mis), .RetireCount__o(be_count)
    );

    mem_wb_stage #(.COUNT_WIDTH(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clock__i(clk), .reset_n__i(rst_n), .Stall__i(stall), .Flush__i(flush),
        .Valid__i(valid), .RegWrite__i(reg_write), .MemToReg__i(mem_to_reg), .Link__i(link),
        .LoadSize__i(load_size), .LoadSigned__i(load_signed), .ByteOffset__i(byte_offset),
        .AddrRd__i(addr_rd), .AluResult__i(alu_result), .MemData__i(mem_data), .Pc4__i(pc4),
        .RegWrite__o(le_rw), .AddrRd__o(le_rd), .DataRd__o(le_data), .Valid__o(le_valid),
        .Misaligned__o(le_mis), .RetireCount__o(le_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; valid = 0; reg_write = 0; mem_to_reg = 0; link = 0;
        load_signed = 0; load_size = 2'b00; byte_offset = 2'b00; addr_rd = 5'd0;
        alu_result = 32'h0; mem_data = 32'h0; pc4 = 32'h0;
    endtask

    task automatic load(input logic [1:0] size, input logic sgn, input logic [1:0] off);
        valid = 1; reg_write = 1; mem_to_reg = 1; link = 0; addr_rd = 5'd8;
        mem_data = 32'h80FF_7F01; load_size = size; load_signed = sgn; byte_offset = off;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #3;
        check("reset_rw",    32'(be_rw), 32'h0);
        check("reset_valid", 32'(be_valid), 32'h0);
        check("reset_count", 32'(be_count), 32'h0);
        #4 rst_n = 1;

        // ALU writeback
        valid = 1; reg_write = 1; addr_rd = 5'd5; alu_result = 32'h1234_5678;
        tick();
        check("alu_rw",    32'(be_rw), 32'h1);
        check("alu_rd",    32'(be_rd), 32'd5);
        check("alu_data",  be_data, 32'h1234_5678);
        check("alu_valid", 32'(be_valid), 32'h1);
        check("alu_count", 32'(be_count), 32'd1);

        // Asynchronous reset between edges
        #2 rst_n = 0;
        #1;
        check("areset_rw",    32'(be_rw), 32'h0);
        check("areset_rd",    32'(be_rd), 32'h0);
        check("areset_data",  be_data, 32'h0);
        check("areset_valid", 32'(be_valid), 32'h0);
        check("areset_count", 32'(be_count), 32'h0);
        #1 rst_n = 1;

        load(2'b00, 1'b1, 2'd0); tick();
        check("lb_s0_be",  be_data, 32'hFFFF_FF80);
        check("lb_s0_le",  le_data, 32'h0000_0001);
        check("lb_s0_rw",  32'(be_rw), 32'h1);
        check("lb_s0_cnt", 32'(be_count), 32'd1);

        load(2'b00, 1'b0, 2'd3); tick();
        check("lbu_3_be", be_data, 32'h0000_0001);
        check("lbu_3_le", le_data, 32'h0000_0080);

        load(2'b01, 1'b1, 2'd2); tick();
        check("lh_s2_be", be_data, 32'h0000_7F01);
        check("lh_s2_le", le_data, 32'hFFFF_80FF);

        load(2'b01, 1'b1, 2'd0); tick();
        check("lh_s0_be",  be_data, 32'hFFFF_80FF);
        check("lh_s0_le",  le_data, 32'h0000_7F01);
        check("lh_s0_cnt", 32'(be_count), 32'd4);

        load(2'b10, 1'b0, 2'd2); tick();
        check("lw_mis_rw",    32'(be_rw), 32'h0);
        check("lw_mis_flag",  32'(be_mis), 32'h1);
        check("lw_mis_valid", 32'(be_valid), 32'h1);
        check("lw_mis_cnt",   32'(be_count), 32'd4);

        // Write to $0: suppressed but retired, data still visible
        mem_to_reg = 0; addr_rd = 5'd0; alu_result = 32'hDEAD_BEEF; tick();
        check("r0_rw",   32'(be_rw), 32'h0);
        check("r0_mis",  32'(be_mis), 32'h0);
        check("r0_data", be_data, 32'hDEAD_BEEF);
        check("r0_cnt",  32'(be_count), 32'd5);

        load(2'b01, 1'b0, 2'd1); tick();
        check("lh_mis_flag", 32'(be_mis), 32'h1);
        check("lh_mis_cnt",  32'(be_count), 32'd5);

        stall = 1; tick();
        check("stall_mis_clr", 32'(be_mis), 32'h0);
        check("stall_mis_rw",  32'(be_rw), 32'h0);
        check("stall_mis_cnt", 32'(be_count), 32'd5);
        stall = 0;

        load(2'b11, 1'b1, 2'd0); tick();
        check("lw_rsv_data", be_data, 32'h80FF_7F01);
        check("lw_rsv_rw",   32'(be_rw), 32'h1);
        check("lw_rsv_cnt",  32'(be_count), 32'd6);

        // jal
        mem_to_reg = 0; link = 1; pc4 = 32'h0040_0004; addr_rd = 5'd31; alu_result = 32'h0;
        tick();
        check("jal_data", be_data, 32'h0040_0008);
        check("jal_rd",   32'(be_rd), 32'd31);
        check("jal_cnt",  32'(be_count), 32'd7);

        stall = 1; link = 0; addr_rd = 5'd3; alu_result = 32'h0000_1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_data", be_data, 32'h0040_0008);
            check("stall_rd",   32'(be_rd), 32'd31);
            check("stall_rw",   32'(be_rw), 32'h1);
            check("stall_cnt",  32'(be_count), 32'd7);
        end

        flush = 1; tick();
        check("sflush_valid", 32'(be_valid), 32'h0);
        check("sflush_rw",    32'(be_rw), 32'h0);
        check("sflush_data",  be_data, 32'h0);
        check("sflush_cnt",   32'(be_count), 32'd7);
        stall = 0; flush = 0;

        valid = 0; reg_write = 1; addr_rd = 5'd4; alu_result = 32'h0000_0055; tick();
        check("inv_rw",    32'(be_rw), 32'h0);
        check("inv_valid", 32'(be_valid), 32'h0);
        check("inv_data",  be_data, 32'h0000_0055);
        check("inv_cnt",   32'(be_count), 32'd7);

        // Counter wrap at 4 bits: 9 more retirements from 7
        valid = 1; addr_rd = 5'd2;
        exp_count = 7;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_count = (exp_count + 1) % 16;
            check("wrap_cnt", 32'(be_count), 32'(exp_count));
        end
        check("wrap_zero", 32'(be_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
